// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register byte offsets, CTRL/STATUS
// bit positions, handshake FSM states and the register-select decoder.
package timer_pkg;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h02;
   localparam logic [7:0] OFF_LOAD_HI  = 8'h04;
   localparam logic [7:0] OFF_LOAD_LO  = 8'h06;
   localparam logic [7:0] OFF_COUNT_HI = 8'h08;
   localparam logic [7:0] OFF_COUNT_LO = 8'h0A;
   localparam logic [7:0] OFF_PRESCALE = 8'h0C;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_AUTO  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_IE    = 3;
   localparam int STATUS_EXP = 0;

   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } state_t;

   typedef enum logic [2:0] {
      SEL_CTRL,
      SEL_STATUS,
      SEL_LOAD_HI,
      SEL_LOAD_LO,
      SEL_COUNT_HI,
      SEL_COUNT_LO,
      SEL_PRESCALE,
      SEL_NONE
   } reg_sel_t;

   // Word-aligned decode: the byte-address LSB is a don't-care.
   function automatic reg_sel_t decode_addr(input logic [7:0] addr);
      reg_sel_t sel;
      casez (addr)
         {OFF_CTRL[7:1],     1'b?}: sel = SEL_CTRL;
         {OFF_STATUS[7:1],   1'b?}: sel = SEL_STATUS;
         {OFF_LOAD_HI[7:1],  1'b?}: sel = SEL_LOAD_HI;
         {OFF_LOAD_LO[7:1],  1'b?}: sel = SEL_LOAD_LO;
         {OFF_COUNT_HI[7:1], 1'b?}: sel = SEL_COUNT_HI;
         {OFF_COUNT_LO[7:1], 1'b?}: sel = SEL_COUNT_LO;
         {OFF_PRESCALE[7:1], 1'b?}: sel = SEL_PRESCALE;
         default:                   sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                                input logic [15:0] new_val,
                                                input logic        uds,
                                                input logic        lds);
      logic [15:0] mask;
      mask = {{8{uds}}, {8{lds}}};
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the timer: counts 0..prescale and emits a one-cycle tick
// on reaching prescale; held at zero while disabled or cleared.
module timer_prescaler (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic [15:0] prescale,
   output logic        tick
);

   logic [15:0] pcnt;

   // Compare with >= so a PRESCALE rewritten below the running count wraps at once.
   assign tick = en && !clr && (pcnt >= prescale);

   always_ff @(posedge clk) begin
      if (reset || clr || !en) begin
         pcnt <= 16'd0;
      end else if (pcnt >= prescale) begin
         pcnt <= 16'd0;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

endmodule

// File: rtl/timer_slave.sv
// 32-bit down-counting timer with prescaler behind the 16-bit uds/lds/ack bus.
// Define TIMER_IRQ_EN to add the registered irq output and a stored CTRL.IE bit.
module timer_slave
   import timer_pkg::*;
#(
   parameter logic [31:0] LOAD_RESET     = 32'hFFFF_FFFF,
   parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bus_write,
   output logic [15:0] bus_read,
   input  logic [7:0]  bus_addr,
   input  logic        bus_we,
   input  logic        bus_uds,
   input  logic        bus_lds,
   output logic        bus_ack
`ifdef TIMER_IRQ_EN
   ,
   output logic        irq
`endif
);

   state_t      state;
   state_t      state_nxt;
   logic        access;
   reg_sel_t    sel;
   logic        wr;
   logic        rd;
   logic        ctrl_wr;
   logic        start;
   logic        exp_clr;
   logic        tick;
   logic        tick_eff;
   logic        expire;
   logic        ctrl_en;
   logic        ctrl_auto;
   logic        status_exp;
   logic [31:0] load;
   logic [31:0] count;
   logic [15:0] count_lo_shadow;
   logic [15:0] prescale;
   logic [15:0] rd_mux;
   logic [15:0] rdata_q;
`ifdef TIMER_IRQ_EN
   logic        ctrl_ie;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A transfer completes only after both strobes drop, so each one acts exactly once.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus_uds || bus_lds)    state_nxt = ST_ACK;
         ST_ACK:  if (!bus_uds && !bus_lds)  state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_ack  = (state == ST_ACK);
      access   = (state == ST_IDLE) && (bus_uds || bus_lds);
      bus_read = bus_ack ? rdata_q : 16'h0000;
   end

   assign sel      = decode_addr(bus_addr);
   assign wr       = access && bus_we;
   assign rd       = access && !bus_we;
   assign ctrl_wr  = wr && (sel == SEL_CTRL) && bus_lds;
   assign start    = ctrl_wr && bus_write[CTRL_START];
   assign exp_clr  = wr && (sel == SEL_STATUS) && bus_lds && bus_write[STATUS_EXP];
   // A CTRL write takes precedence over a coincident tick.
   assign tick_eff = tick && !ctrl_wr;
   assign expire   = tick_eff && (count == 32'd0);

   timer_prescaler u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (ctrl_en),
      .clr      (start),
      .prescale (prescale),
      .tick     (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_en   <= 1'b0;
         ctrl_auto <= 1'b0;
      end else if (ctrl_wr) begin
         ctrl_en   <= bus_write[CTRL_EN];
         ctrl_auto <= bus_write[CTRL_AUTO];
      end else if (expire && !ctrl_auto) begin
         ctrl_en   <= 1'b0;
      end
   end

`ifdef TIMER_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_ie <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (ctrl_wr) ctrl_ie <= bus_write[CTRL_IE];
         irq <= status_exp && ctrl_ie;
      end
   end
`endif

   // Expiry beats a same-cycle W1C so an event is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         status_exp <= 1'b0;
      end else if (expire) begin
         status_exp <= 1'b1;
      end else if (exp_clr) begin
         status_exp <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= LOAD_RESET;
      end else if (start) begin
         count <= load;
      end else if (tick_eff) begin
         if (count != 32'd0) begin
            count <= count - 32'd1;
         end else if (ctrl_auto) begin
            count <= load;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load     <= LOAD_RESET;
         prescale <= PRESCALE_RESET;
      end else if (wr) begin
         case (sel)
            SEL_LOAD_HI:  load[31:16] <= merge_lanes(load[31:16], bus_write, bus_uds, bus_lds);
            SEL_LOAD_LO:  load[15:0]  <= merge_lanes(load[15:0],  bus_write, bus_uds, bus_lds);
            SEL_PRESCALE: prescale    <= merge_lanes(prescale,    bus_write, bus_uds, bus_lds);
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = 16'h0000;
      case (sel)
         SEL_CTRL: begin
            rd_mux[CTRL_EN]   = ctrl_en;
            rd_mux[CTRL_AUTO] = ctrl_auto;
`ifdef TIMER_IRQ_EN
            rd_mux[CTRL_IE]   = ctrl_ie;
`endif
         end
         SEL_STATUS:   rd_mux[STATUS_EXP] = status_exp;
         SEL_LOAD_HI:  rd_mux = load[31:16];
         SEL_LOAD_LO:  rd_mux = load[15:0];
         SEL_COUNT_HI: rd_mux = count[31:16];
         SEL_COUNT_LO: rd_mux = count_lo_shadow;
         SEL_PRESCALE: rd_mux = prescale;
         default:      rd_mux = 16'h0000;
      endcase
   end

   // Reading COUNT_HI snapshots the low half so a HI-then-LO pair is coherent.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_lo_shadow <= LOAD_RESET[15:0];
         rdata_q         <= 16'h0000;
      end else if (access) begin
         rdata_q <= rd ? rd_mux : 16'h0000;
         if (rd && (sel == SEL_COUNT_HI)) begin
            count_lo_shadow <= count[15:0];
         end
      end
   end

endmodule

// File: tb/tb_timer_slave.sv
// Self-checking bench for timer_slave: bus reads are scored against a queue of
// expected values; TIMER_IRQ_EN builds also exercise the irq output.
module tb_timer_slave;

   logic        clk;
   logic        reset;
   logic [15:0] bus_write;
   logic [15:0] bus_read;
   logic [7:0]  bus_addr;
   logic        bus_we;
   logic        bus_uds;
   logic        bus_lds;
   logic        bus_ack;
`ifdef TIMER_IRQ_EN
   logic        irq;
`endif

   typedef struct {
      string       tag;
      logic [15:0] data;
   } expect_t;

   expect_t sb_queue[$];
   int      check_count;
   int      error_count;

   timer_slave dut (
      .clk       (clk),
      .reset     (reset),
      .bus_write (bus_write),
      .bus_read  (bus_read),
      .bus_addr  (bus_addr),
      .bus_we    (bus_we),
      .bus_uds   (bus_uds),
      .bus_lds   (bus_lds),
      .bus_ack   (bus_ack)
`ifdef TIMER_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One complete transfer: strobe cycle, ack cycle with strobes low, back to idle.
   task automatic applyStimulus(input logic [7:0] addr, input logic we, input logic [15:0] data,
                                input logic uds, input logic lds, input string tag);
      expect_t e;
      bus_addr  = addr;
      bus_we    = we;
      bus_write = data;
      bus_uds   = uds;
      bus_lds   = lds;
      @(posedge clk);
      #1;
      checkOutput({tag, "_ack"}, {31'd0, bus_ack}, 32'd1);
      if (!we && sb_queue.size() > 0) begin
         e = sb_queue.pop_front();
         checkOutput(e.tag, {16'd0, bus_read}, {16'd0, e.data});
      end
      bus_uds = 1'b0;
      bus_lds = 1'b0;
      bus_we  = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, "_ackfall"}, {31'd0, bus_ack}, 32'd0);
      checkOutput({tag, "_rdzero"}, {16'd0, bus_read}, 32'd0);
   endtask

   task automatic busWrite(input logic [7:0] addr, input logic [15:0] data, input string tag);
      applyStimulus(addr, 1'b1, data, 1'b1, 1'b1, tag);
   endtask

   task automatic busRead(input logic [7:0] addr, input logic [15:0] expected, input string tag);
      expect_t e;
      e.tag  = tag;
      e.data = expected;
      sb_queue.push_back(e);
      applyStimulus(addr, 1'b0, 16'h0000, 1'b1, 1'b1, tag);
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      // Reset with a write pending on the bus: it must be discarded.
      reset     = 1'b1;
      bus_addr  = 8'h06;
      bus_we    = 1'b1;
      bus_write = 16'h1234;
      bus_uds   = 1'b1;
      bus_lds   = 1'b1;
      idle(3);
      checkOutput("rst_ack", {31'd0, bus_ack}, 32'd0);
      checkOutput("rst_read", {16'd0, bus_read}, 32'd0);
      bus_uds = 1'b0;
      bus_lds = 1'b0;
      bus_we  = 1'b0;
      idle(1);
      reset = 1'b0;
      idle(1);

      busRead(8'h04, 16'hFFFF, "rst_load_hi");
      busRead(8'h06, 16'hFFFF, "rst_load_lo");
      busRead(8'h00, 16'h0000, "rst_ctrl");
      busRead(8'h02, 16'h0000, "rst_status");
      busRead(8'h0C, 16'h0000, "rst_prescale");
      busRead(8'h08, 16'hFFFF, "rst_count_hi");
      busRead(8'h0A, 16'hFFFF, "rst_count_lo");

      applyStimulus(8'h04, 1'b1, 16'hABCD, 1'b1, 1'b0, "wr_uds_only");
      busRead(8'h05, 16'hABFF, "uds_lane_load_hi");
      busWrite(8'h0E, 16'hFFFF, "wr_unmapped");
      busRead(8'h0E, 16'h0000, "rd_unmapped");

      // One-shot: LOAD=3, PRESCALE=0, EN|START.
      busWrite(8'h04, 16'h0000, "wr_load_hi");
      busWrite(8'h06, 16'h0003, "wr_load_lo");
      busWrite(8'h00, 16'h0005, "wr_ctrl_start");
      idle(1);
      busRead(8'h08, 16'h0000, "os_count_hi");
      busRead(8'h0A, 16'h0001, "os_count_lo");
      busRead(8'h02, 16'h0001, "os_exp");
      busRead(8'h00, 16'h0000, "os_en_cleared");
      busRead(8'h08, 16'h0000, "os_final_hi");
      busRead(8'h0A, 16'h0000, "os_final_lo");
      busWrite(8'h02, 16'h0001, "w1c");
      busRead(8'h02, 16'h0000, "os_exp_cleared");

      // W1C landing on the expiry edge must leave EXP set.
      busWrite(8'h00, 16'h0005, "wr_ctrl_start2");
      idle(2);
      busWrite(8'h02, 16'h0001, "w1c_on_expiry");
      busRead(8'h02, 16'h0001, "exp_survives_w1c");
      busWrite(8'h02, 16'h0001, "w1c2");
      busRead(8'h02, 16'h0000, "exp_cleared2");

      // One cycle later the same W1C clears it.
      busWrite(8'h00, 16'h0005, "wr_ctrl_start3");
      idle(3);
      busWrite(8'h02, 16'h0001, "w1c_after_expiry");
      busRead(8'h02, 16'h0000, "exp_cleared3");

      // Auto-reload: LOAD=2, PRESCALE=1 gives an expiry every 6 clocks.
      busWrite(8'h06, 16'h0002, "wr_load_lo2");
      busWrite(8'h0C, 16'h0001, "wr_prescale");
      busWrite(8'h00, 16'h0007, "wr_ctrl_auto");
      idle(5);
      busWrite(8'h02, 16'h0001, "w1c_auto");
      idle(2);
      busRead(8'h02, 16'h0000, "auto_before_2nd");
      busRead(8'h02, 16'h0001, "auto_2nd_exp");
      busRead(8'h08, 16'h0000, "auto_count_hi");
      busRead(8'h0A, 16'h0001, "auto_count_lo");
      busRead(8'h00, 16'h0003, "auto_ctrl_start_rd0");
      busWrite(8'h00, 16'h0000, "stop_auto");
      busWrite(8'h02, 16'h0001, "w1c_auto2");
      busRead(8'h02, 16'h0000, "auto_exp_cleared");

      // Coherent 32-bit read across a low-half borrow.
      busWrite(8'h04, 16'h0001, "wr_load_hi2");
      busWrite(8'h06, 16'h0002, "wr_load_lo3");
      busWrite(8'h0C, 16'h0000, "wr_prescale0");
      busWrite(8'h00, 16'h0005, "wr_ctrl_start4");
      idle(1);
      busRead(8'h08, 16'h0001, "coh_count_hi");
      busRead(8'h0A, 16'h0000, "coh_count_lo");
      busWrite(8'h00, 16'h0000, "stop_coh");

`ifdef TIMER_IRQ_EN
      busWrite(8'h04, 16'h0000, "irq_load_hi");
      busWrite(8'h06, 16'h0003, "irq_load_lo");
      busWrite(8'h00, 16'h000D, "irq_ctrl");
      idle(3);
      checkOutput("irq_on_exp_edge", {31'd0, irq}, 32'd0);
      idle(1);
      checkOutput("irq_rise", {31'd0, irq}, 32'd1);
      busRead(8'h00, 16'h0008, "irq_ctrl_ie");
      busWrite(8'h02, 16'h0001, "irq_w1c");
      idle(1);
      checkOutput("irq_fall", {31'd0, irq}, 32'd0);
`endif

      // Reset while a read is being acknowledged.
      bus_addr = 8'h04;
      bus_we   = 1'b0;
      bus_uds  = 1'b1;
      bus_lds  = 1'b1;
      idle(1);
      checkOutput("midrst_ack_before", {31'd0, bus_ack}, 32'd1);
      reset = 1'b1;
      idle(1);
      checkOutput("midrst_ack_drop", {31'd0, bus_ack}, 32'd0);
      bus_uds = 1'b0;
      bus_lds = 1'b0;
      reset   = 1'b0;
      idle(1);
      busRead(8'h04, 16'hFFFF, "midrst_load_hi");
      checkOutput("sb_empty", sb_queue.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
